// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing,
// used by both the echo transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int unsigned BIT_CNT_MAX_DEFAULT  = 104;
    localparam int unsigned BIT_CNT_HALF_DEFAULT = 52;

    // Serial bytes leave LSB first, so the shift register always moves right.
    function automatic logic [7:0] lsb_shift(input logic [7:0] value);
        return {1'b0, value[7:1]};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO with a registered occupancy count. A write that meets a
// full count is dropped and flagged with a one-cycle overflow pulse.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic             overflow_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full is taken from the registered count, so a pop on the same edge
    // never frees room for a write.
    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nx_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nx_s = count_r + CNT_W'(1);
            2'b01:   count_nx_s = count_r - CNT_W'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Pointers, count and overflow pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_nx_s;
            overflow_r <= push & full_s;
        end
    end

    // Storage array; contents are only meaningful under the count.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_r;

endmodule

// File: rtl/uart_tx_echo.sv
// 8N1 UART transmitter that echoes received bytes back to the host,
// buffering bytes that arrive while a frame is on the line.
module uart_tx_echo
    import uart_pkg::*;
#(
    parameter int BIT_CNT_MAX = BIT_CNT_MAX_DEFAULT,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int BIT_W = $clog2(BIT_CNT_MAX + 1);

    uart_state_t      state_r;
    uart_state_t      state_nx_s;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [BIT_W-1:0] bit_cnt_nx_s;
    logic [2:0]       data_cnt_r;
    logic [2:0]       data_cnt_nx_s;
    logic [7:0]       shreg_r;
    logic [7:0]       shreg_nx_s;
    logic             tx_r;
    logic             tx_nx_s;
    logic             pop_s;
    logic             counter_end_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             fifo_overflow_s;
    logic [7:0]       fifo_head_s;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .overflow  (fifo_overflow_s)
    );

    assign counter_end_s = (bit_cnt_r == BIT_W'(BIT_CNT_MAX));

    // Bit timer: parked at zero while idle, otherwise wraps every bit period.
    always_comb begin
        bit_cnt_nx_s = bit_cnt_r;
        if (state_r == IDLE) begin
            bit_cnt_nx_s = {BIT_W{1'b0}};
        end else if (counter_end_s) begin
            bit_cnt_nx_s = {BIT_W{1'b0}};
        end else begin
            bit_cnt_nx_s = bit_cnt_r + BIT_W'(1);
        end
    end

    // Frame sequencing; tx is computed one edge ahead so the pin is a flop.
    always_comb begin
        state_nx_s    = state_r;
        tx_nx_s       = tx_r;
        shreg_nx_s    = shreg_r;
        data_cnt_nx_s = data_cnt_r;
        pop_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s         = 1'b1;
                    shreg_nx_s    = fifo_head_s;
                    data_cnt_nx_s = 3'd0;
                    tx_nx_s       = 1'b0;
                    state_nx_s    = START;
                end else begin
                    tx_nx_s = 1'b1;
                end
            end
            START: begin
                if (counter_end_s) begin
                    tx_nx_s    = shreg_r[0];
                    shreg_nx_s = lsb_shift(shreg_r);
                    state_nx_s = DATA;
                end else begin
                    tx_nx_s = 1'b0;
                end
            end
            DATA: begin
                if (counter_end_s) begin
                    if (data_cnt_r == 3'd7) begin
                        tx_nx_s    = 1'b1;
                        state_nx_s = STOP;
                    end else begin
                        tx_nx_s       = shreg_r[0];
                        shreg_nx_s    = lsb_shift(shreg_r);
                        data_cnt_nx_s = data_cnt_r + 3'd1;
                    end
                end else begin
                    tx_nx_s = tx_r;
                end
            end
            STOP: begin
                if (counter_end_s) begin
                    if (!fifo_empty_s) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop_s         = 1'b1;
                        shreg_nx_s    = fifo_head_s;
                        data_cnt_nx_s = 3'd0;
                        tx_nx_s       = 1'b0;
                        state_nx_s    = START;
                    end else begin
                        tx_nx_s    = 1'b1;
                        state_nx_s = IDLE;
                    end
                end else begin
                    tx_nx_s = 1'b1;
                end
            end
            default: begin
                tx_nx_s    = 1'b1;
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, timer, shifter and line register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= {BIT_W{1'b0}};
            data_cnt_r <= 3'd0;
            shreg_r    <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            data_cnt_r <= data_cnt_nx_s;
            shreg_r    <= shreg_nx_s;
            tx_r       <= tx_nx_s;
        end
    end

    assign tx        = tx_r;
    assign busy      = (state_r != IDLE) | ~fifo_empty_s;
    assign fifo_full = fifo_full_s;
    assign overflow  = fifo_overflow_s;

endmodule
